// File: rtl/boot_loader.sv
// Serial program loader and RAM-port arbiter: assembles byte pairs into 16-bit
// words written to consecutive RAM addresses, then hands the port to the CPU.
module boot_loader #(
  parameter int unsigned WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload,
  input  logic [5:0]  cpu_adr,
  input  logic [15:0] cpu_data,
  input  logic        cpu_w_mem,
  input  logic        cpu_enable_mem,
  output logic        boot,
  output logic [5:0]  mem_adr,
  output logic [15:0] mem_data,
  output logic        mem_w,
  output logic        mem_en,
  output logic        overrun
);

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, WRITE, RUN} state_t;

  localparam logic [5:0] LAST = 6'(WORDS - 1);

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic [7:0] hi, hi_nx;
  logic [7:0] lo, lo_nx;
  logic       ovr, ovr_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_HI;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      ovr   <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    ovr_nx   = ovr;
    if (ce) begin
      case (state)
        LOAD_HI: if (rx_valid) begin
          hi_nx    = rx_data;
          state_nx = LOAD_LO;
        end
        LOAD_LO: if (rx_valid) begin
          lo_nx    = rx_data;
          state_nx = WRITE;
        end
        WRITE: begin
          // A byte arriving while the word is committed cannot be buffered.
          if (rx_valid) ovr_nx = 1'b1;
          if (cnt == LAST) begin
            cnt_nx   = '0;
            state_nx = RUN;
          end else begin
            cnt_nx   = cnt + 6'd1;
            state_nx = LOAD_HI;
          end
        end
        RUN: if (reload) begin
          cnt_nx   = '0;
          ovr_nx   = 1'b0;
          state_nx = LOAD_HI;
        end
        default: state_nx = LOAD_HI;
      endcase
    end
  end

  always_comb begin
    boot     = (state != RUN);
    overrun  = ovr;
    mem_adr  = cnt;
    mem_data = {hi, lo};
    mem_w    = 1'b0;
    mem_en   = 1'b0;
    case (state)
      WRITE: begin
        mem_w  = ce;
        mem_en = ce;
      end
      RUN: begin
        mem_adr  = cpu_adr;
        mem_data = cpu_data;
        mem_w    = cpu_w_mem;
        mem_en   = cpu_enable_mem;
      end
      default: ;
    endcase
  end

endmodule
